btb_update_unit: RTL and testbench

Branch resolution and BTB writer for the execute stage. Compares the fetch-time prediction with the resolved outcome of each control-transfer instruction and raises a one-cycle flush with the correct redirect PC. Maintains a local table of 2-bit saturating counters and drives the BTB write port (enable, branch PC, target PC, state bit) one cycle after resolution. Sits between EX and the BTB/fetch unit, and also keeps misprediction statistics.

---
 rtl/btb_update_unit_pkg.sv | 9 +
 rtl/btb_update_unit_if.sv | 27 ++
 rtl/btb_update_unit_bht_counter_table.sv | 27 ++
 rtl/btb_update_unit.sv | 53 +++++
 tb/tb_btb_update_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/btb_update_unit_pkg.sv
// btb_update_unit_pkg: counter encodings, reset level, PC increment and the saturating-counter update.
package btb_update_unit_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} cnt_e;
  localparam logic RESET_ENABLE = 1'b0;
  localparam logic [31:0] PC_INC = 32'd4;
  function automatic cnt_e cnt_next(input cnt_e c, input logic is_cond, input logic taken);
    return !is_cond ? ST : taken ? (c == ST ? ST : cnt_e'(c + 2'd1)) : (c == SNT ? SNT : cnt_e'(c - 2'd1));
  endfunction
endpackage

// File: rtl/btb_update_unit_if.sv
// btb_update_unit_if: EX resolution inputs, flush/redirect, BTB write port and statistics.
interface btb_update_unit_if #(parameter int CNT_W = 32);
  logic              ex_valid_i;
  logic [31:0]       ex_pc_i;
  logic              ex_is_cond_i;
  logic              ex_taken_i;
  logic [31:0]       ex_target_i;
  logic              ex_pred_taken_i;
  logic [31:0]       ex_pred_pc_i;
  logic              stall_i;
  logic              flush_o;
  logic [31:0]       redirect_pc_o;
  logic              btb_en_o;
  logic [31:0]       btb_wr_pc_o;
  logic [31:0]       btb_wr_pred_pc_o;
  logic              btb_wr_state_o;
  logic [CNT_W-1:0]  branch_cnt_o;
  logic [CNT_W-1:0]  mispredict_cnt_o;
  modport master (
    output ex_valid_i, ex_pc_i, ex_is_cond_i, ex_taken_i, ex_target_i, ex_pred_taken_i, ex_pred_pc_i, stall_i,
    input  flush_o, redirect_pc_o, btb_en_o, btb_wr_pc_o, btb_wr_pred_pc_o, btb_wr_state_o, branch_cnt_o, mispredict_cnt_o
  );
  modport slave (
    input  ex_valid_i, ex_pc_i, ex_is_cond_i, ex_taken_i, ex_target_i, ex_pred_taken_i, ex_pred_pc_i, stall_i,
    output flush_o, redirect_pc_o, btb_en_o, btb_wr_pc_o, btb_wr_pred_pc_o, btb_wr_state_o, branch_cnt_o, mispredict_cnt_o
  );
endinterface

// File: rtl/btb_update_unit_bht_counter_table.sv
// bht_counter_table: 2-bit saturating counters, combinational read, synchronous write, async reset to WNT.
module bht_counter_table
  import btb_update_unit_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] idx_i,
  input  logic          we_i,
  input  logic          is_cond_i,
  input  logic          taken_i,
  output logic          cnt_msb_o,
  output logic          new_msb_o
);
  cnt_e tbl [2**AW];
  cnt_e cnt, new_cnt;
  assign cnt       = tbl[idx_i];
  assign new_cnt   = cnt_next(cnt, is_cond_i, taken_i);
  assign cnt_msb_o = cnt[1];
  assign new_msb_o = new_cnt[1];
  always_ff @(posedge clk_i or negedge rst_i)
    if (rst_i == RESET_ENABLE)
      for (int i = 0; i < 2**AW; i++) tbl[i] <= WNT;
    else if (we_i)
      tbl[idx_i] <= new_cnt;
endmodule

// File: rtl/btb_update_unit.sv
// btb_update_unit: resolves EX control transfers, raises flush/redirect, drives the BTB write port
// and counts branches and mispredictions.
module btb_update_unit
  import btb_update_unit_pkg::*;
#(
  parameter int BHT_ADDR_LEN = 6,
  parameter int CNT_W        = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  btb_update_unit_if.slave bus
);
  logic        eval, taken, mispredict, btb_wr, cnt_msb, new_msb;
  logic [31:0] seq_pc, act_npc, pred_npc;
  // flush_o masks eval so the wrong-path instruction behind a mispredict is never resolved
  assign eval       = bus.ex_valid_i & ~bus.stall_i & ~bus.flush_o;
  assign taken      = bus.ex_is_cond_i ? bus.ex_taken_i : 1'b1;
  assign seq_pc     = bus.ex_pc_i + PC_INC;
  assign act_npc    = taken ? bus.ex_target_i : seq_pc;
  assign pred_npc   = bus.ex_pred_taken_i ? bus.ex_pred_pc_i : seq_pc;
  assign mispredict = eval & (act_npc != pred_npc);
  assign btb_wr     = eval & ((taken & (~bus.ex_pred_taken_i | (bus.ex_pred_pc_i != bus.ex_target_i))) | (new_msb != cnt_msb));
  bht_counter_table #(.AW(BHT_ADDR_LEN)) u_tbl (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .idx_i     (bus.ex_pc_i[BHT_ADDR_LEN+1:2]),
    .we_i      (eval),
    .is_cond_i (bus.ex_is_cond_i),
    .taken_i   (taken),
    .cnt_msb_o (cnt_msb),
    .new_msb_o (new_msb)
  );
  always_ff @(posedge clk_i or negedge rst_i)
    if (rst_i == RESET_ENABLE) begin
      bus.flush_o          <= 1'b0;
      bus.redirect_pc_o    <= '0;
      bus.btb_en_o         <= 1'b0;
      bus.btb_wr_pc_o      <= '0;
      bus.btb_wr_pred_pc_o <= '0;
      bus.btb_wr_state_o   <= 1'b0;
      bus.branch_cnt_o     <= '0;
      bus.mispredict_cnt_o <= '0;
    end else begin
      bus.flush_o          <= mispredict;
      bus.btb_en_o         <= btb_wr;
      bus.redirect_pc_o    <= mispredict ? act_npc : bus.redirect_pc_o;
      bus.btb_wr_pc_o      <= btb_wr ? bus.ex_pc_i : bus.btb_wr_pc_o;
      bus.btb_wr_pred_pc_o <= btb_wr ? bus.ex_target_i : bus.btb_wr_pred_pc_o;
      bus.btb_wr_state_o   <= btb_wr ? new_msb : bus.btb_wr_state_o;
      bus.branch_cnt_o     <= bus.branch_cnt_o + CNT_W'(eval);
      bus.mispredict_cnt_o <= bus.mispredict_cnt_o + CNT_W'(mispredict);
    end
endmodule

// File: tb/tb_btb_update_unit.sv
// tb_btb_update_unit: scoreboard bench; a narrow-counter second instance exercises statistics wrap.
module tb_btb_update_unit;
  typedef struct packed {
    logic        flush;
    logic [31:0] redir;
    logic        en;
    logic [31:0] wpc;
    logic [31:0] wtgt;
    logic        st;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  int m_tbl [64];
  logic m_flush;
  logic [31:0] m_b, m_m;
  out_t m_out, e, a;
  out_t q [$];

  always #5 clk = ~clk;

  btb_update_unit_if #(.CNT_W(32)) bus ();
  btb_update_unit_if #(.CNT_W(4))  bus_w ();

  assign bus_w.ex_valid_i      = bus.ex_valid_i;
  assign bus_w.ex_pc_i         = bus.ex_pc_i;
  assign bus_w.ex_is_cond_i    = bus.ex_is_cond_i;
  assign bus_w.ex_taken_i      = bus.ex_taken_i;
  assign bus_w.ex_target_i     = bus.ex_target_i;
  assign bus_w.ex_pred_taken_i = bus.ex_pred_taken_i;
  assign bus_w.ex_pred_pc_i    = bus.ex_pred_pc_i;
  assign bus_w.stall_i         = bus.stall_i;

  btb_update_unit #(.BHT_ADDR_LEN(6), .CNT_W(32)) dut   (.clk_i(clk), .rst_i(rst), .bus(bus));
  btb_update_unit #(.BHT_ADDR_LEN(6), .CNT_W(4))  dut_w (.clk_i(clk), .rst_i(rst), .bus(bus_w));

  function automatic out_t obs();
    return {bus.flush_o, bus.redirect_pc_o, bus.btb_en_o, bus.btb_wr_pc_o, bus.btb_wr_pred_pc_o, bus.btb_wr_state_o};
  endfunction

  task automatic issue(input logic v, input logic [31:0] pc, input logic cond, input logic tk,
                       input logic [31:0] tgt, input logic pt, input logic [31:0] ppc, input logic stl);
    logic ev, t, mis, wr;
    logic [31:0] act, prd;
    int idx, c, nc;
    @(negedge clk);
    bus.ex_valid_i = v; bus.ex_pc_i = pc; bus.ex_is_cond_i = cond; bus.ex_taken_i = tk;
    bus.ex_target_i = tgt; bus.ex_pred_taken_i = pt; bus.ex_pred_pc_i = ppc; bus.stall_i = stl;
    ev  = v & ~stl & ~m_flush;
    t   = cond ? tk : 1'b1;
    act = t ? tgt : pc + 32'd4;
    prd = pt ? ppc : pc + 32'd4;
    mis = ev & (act != prd);
    idx = int'(pc[7:2]);
    c   = m_tbl[idx];
    nc  = !cond ? 3 : t ? (c == 3 ? 3 : c + 1) : (c == 0 ? 0 : c - 1);
    wr  = ev & ((t & (!pt | (ppc != tgt))) | ((nc >= 2) != (c >= 2)));
    if (ev) m_tbl[idx] = nc;
    m_b = m_b + 32'(ev);
    m_m = m_m + 32'(mis);
    m_flush = mis;
    m_out.flush = mis;
    m_out.en = wr;
    if (mis) m_out.redir = act;
    if (wr) begin
      m_out.wpc = pc;
      m_out.wtgt = tgt;
      m_out.st = nc >= 2;
    end
    q.push_back(m_out);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    a = obs();
    tests++; if (a !== '0) begin fails++; $display("FAIL reset_outputs got %h exp 0", a); end
    tests++; if (bus.branch_cnt_o !== 32'h0) begin fails++; $display("FAIL reset_branch_cnt got %h exp 0", bus.branch_cnt_o); end
    tests++; if (bus.mispredict_cnt_o !== 32'h0) begin fails++; $display("FAIL reset_mispredict_cnt got %h exp 0", bus.mispredict_cnt_o); end
  endtask

  task automatic test_first_branch();
    issue(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    e = q.pop_front(); a = obs();
    tests++; if (a !== e) begin fails++; $display("FAIL first_branch got %h exp %h", a, e); end
    tests++; if (a !== {1'b1, 32'h200, 1'b1, 32'h100, 32'h200, 1'b1}) begin fails++; $display("FAIL first_branch_literal got %h", a); end
    tests++; if (bus.mispredict_cnt_o !== 32'd1) begin fails++; $display("FAIL first_mispredict_cnt got %h exp 1", bus.mispredict_cnt_o); end
    idle();
    e = q.pop_front(); a = obs();
    tests++; if (a !== e || a.flush !== 1'b0 || a.en !== 1'b0) begin fails++; $display("FAIL first_pulse_end got %h exp %h", a, e); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
      e = q.pop_front(); a = obs();
      tests++; if (a !== e || a.flush !== 1'b0 || a.en !== 1'b0) begin fails++; $display("FAIL saturate_%0d got %h exp %h", i, a, e); end
    end
  endtask

  task automatic test_not_taken();
    issue(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 32'h200, 1'b0);
    e = q.pop_front(); a = obs();
    tests++; if (a !== e || a.flush !== 1'b1 || a.redir !== 32'h104 || a.en !== 1'b0) begin fails++; $display("FAIL not_taken_1 got %h exp %h", a, e); end
    idle();
    e = q.pop_front(); a = obs();
    tests++; if (a !== e) begin fails++; $display("FAIL not_taken_gap got %h exp %h", a, e); end
    issue(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 32'h200, 1'b0);
    e = q.pop_front(); a = obs();
    tests++; if (a !== e || a !== {1'b1, 32'h104, 1'b1, 32'h100, 32'h200, 1'b0}) begin fails++; $display("FAIL not_taken_2 got %h exp %h", a, e); end
    idle();
    e = q.pop_front(); a = obs();
    tests++; if (a !== e) begin fails++; $display("FAIL not_taken_end got %h exp %h", a, e); end
  endtask

  task automatic test_jal();
    issue(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 1'b0, 32'h0, 1'b0);
    e = q.pop_front(); a = obs();
    tests++; if (a !== e || a.flush !== 1'b0 || a.en !== 1'b0) begin fails++; $display("FAIL jal_setup got %h exp %h", a, e); end
    issue(1'b1, 32'h40, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0, 1'b0);
    e = q.pop_front(); a = obs();
    tests++; if (a !== e || a !== {1'b1, 32'h80, 1'b1, 32'h40, 32'h80, 1'b1}) begin fails++; $display("FAIL jal got %h exp %h", a, e); end
    idle();
    e = q.pop_front(); a = obs();
    tests++; if (a !== e) begin fails++; $display("FAIL jal_end got %h exp %h", a, e); end
  endtask

  task automatic test_stall();
    logic [31:0] b0;
    b0 = bus.branch_cnt_o;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 32'h304, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0, i < 3);
      e = q.pop_front(); a = obs();
      tests++; if (a !== e) begin fails++; $display("FAIL stall_%0d got %h exp %h", i, a, e); end
    end
    tests++; if (bus.branch_cnt_o - b0 !== 32'd1) begin fails++; $display("FAIL stall_one_eval got %0d exp 1", bus.branch_cnt_o - b0); end
    idle();
    e = q.pop_front(); a = obs();
    tests++; if (a !== e) begin fails++; $display("FAIL stall_end got %h exp %h", a, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] b0, m0;
    issue(1'b1, 32'h108, 1'b1, 1'b1, 32'h208, 1'b0, 32'h0, 1'b0);
    e = q.pop_front(); a = obs();
    tests++; if (a !== e || a.flush !== 1'b1) begin fails++; $display("FAIL b2b_mis got %h exp %h", a, e); end
    b0 = bus.branch_cnt_o; m0 = bus.mispredict_cnt_o;
    issue(1'b1, 32'h10c, 1'b1, 1'b1, 32'h20c, 1'b0, 32'h0, 1'b0);
    e = q.pop_front(); a = obs();
    tests++; if (a !== e || a.flush !== 1'b0 || a.en !== 1'b0) begin fails++; $display("FAIL b2b_ignored got %h exp %h", a, e); end
    tests++; if (bus.branch_cnt_o !== b0 || bus.mispredict_cnt_o !== m0) begin fails++; $display("FAIL b2b_stats got %h/%h exp %h/%h", bus.branch_cnt_o, bus.mispredict_cnt_o, b0, m0); end
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, 32'h10c, 1'b1, 1'b1, 32'h20c, 1'b1, 32'h20c, 1'b0);
      e = q.pop_front(); a = obs();
      tests++; if (a !== e || a.en !== (i == 0)) begin fails++; $display("FAIL b2b_same_idx_%0d got %h exp %h", i, a, e); end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      issue(1'b1, 32'h110, 1'b1, 1'b1, 32'h700 + 32'(i), 1'b0, 32'h0, 1'b0);
      e = q.pop_front(); a = obs();
      tests++; if (a !== e) begin fails++; $display("FAIL wrap_out_%0d got %h exp %h", i, a, e); end
      tests++; if (bus_w.branch_cnt_o !== m_b[3:0] || bus_w.mispredict_cnt_o !== m_m[3:0]) begin
        fails++; $display("FAIL wrap_cnt_%0d got %h/%h exp %h/%h", i, bus_w.branch_cnt_o, bus_w.mispredict_cnt_o, m_b[3:0], m_m[3:0]);
      end
      idle();
      e = q.pop_front();
    end
    tests++; if (bus.branch_cnt_o !== m_b || bus.mispredict_cnt_o !== m_m) begin fails++; $display("FAIL wrap_main_cnt got %h/%h exp %h/%h", bus.branch_cnt_o, bus.mispredict_cnt_o, m_b, m_m); end
  endtask

  task automatic test_async_reset();
    issue(1'b1, 32'h114, 1'b1, 1'b1, 32'h900, 1'b0, 32'h0, 1'b0);
    e = q.pop_front(); a = obs();
    tests++; if (a !== e || a.flush !== 1'b1 || a.en !== 1'b1) begin fails++; $display("FAIL arst_pending got %h exp %h", a, e); end
    #1 rst = 1'b0;
    #1 a = obs();
    tests++; if (a !== '0) begin fails++; $display("FAIL arst_drop got %h exp 0", a); end
    tests++; if (bus.branch_cnt_o !== 32'h0 || bus.mispredict_cnt_o !== 32'h0) begin fails++; $display("FAIL arst_cnt got %h/%h exp 0/0", bus.branch_cnt_o, bus.mispredict_cnt_o); end
    @(negedge clk) rst = 1'b1;
  endtask

  initial begin
    bus.ex_valid_i = 1'b0; bus.ex_pc_i = '0; bus.ex_is_cond_i = 1'b0; bus.ex_taken_i = 1'b0;
    bus.ex_target_i = '0; bus.ex_pred_taken_i = 1'b0; bus.ex_pred_pc_i = '0; bus.stall_i = 1'b0;
    for (int i = 0; i < 64; i++) m_tbl[i] = 1;
    m_flush = 1'b0; m_b = '0; m_m = '0; m_out = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    test_reset();
    test_first_branch();
    test_saturate();
    test_not_taken();
    test_jal();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
